// File: rtl/gray_to_bin_decoder_pkg.sv
// Shared widths, step-class encoding and the Gray-to-binary decode function
// for the Gray decoder and its step checker.
package gray_to_bin_decoder_pkg;

  localparam int W_DEFAULT  = 4;
  localparam int CW_DEFAULT = 8;
  localparam int GRAY_MAX_W = 32;

  typedef enum logic [2:0] {
    STEP_FIRST = 3'd0,
    STEP_HOLD  = 3'd1,
    STEP_UP    = 3'd2,
    STEP_DOWN  = 3'd3,
    STEP_ERR   = 3'd4
  } step_class_e;

  // Narrower codes are zero-extended by the caller; leading zeros decode to zeros.
  function automatic logic [GRAY_MAX_W-1:0] gray_to_bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = g;
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_to_bin_decoder_step_checker.sv
// Sequence checker: classifies each accepted value against the previous one
// (+1 / -1 modulo 2^W) and keeps a saturating violation count.
module gray_step_checker
  import gray_to_bin_decoder_pkg::*;
#(
  parameter int W  = W_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          accept,
  input  logic [W-1:0]  bin,
  output logic          step_dir,
  output logic          step_err,
  output logic [CW-1:0] err_cnt
);

  logic [W-1:0]  prev_bin_q, prev_bin_d;
  logic          have_prev_q, have_prev_d;
  logic          step_dir_q, step_dir_d;
  logic          step_err_q, step_err_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic [W-1:0]  diff_s;
  step_class_e   step_class_s;

  // Classify the incoming value by its modular distance from the previous one.
  always_comb begin
    diff_s = bin - prev_bin_q;
    if (!have_prev_q) begin
      step_class_s = STEP_FIRST;
    end else if (diff_s == {W{1'b0}}) begin
      step_class_s = STEP_HOLD;
    end else if (diff_s == {{(W-1){1'b0}}, 1'b1}) begin
      step_class_s = STEP_UP;
    end else if (diff_s == {W{1'b1}}) begin
      step_class_s = STEP_DOWN;
    end else begin
      step_class_s = STEP_ERR;
    end
  end

  // Next-state for history, step flags and counter; everything moves only on accept.
  always_comb begin
    prev_bin_d  = prev_bin_q;
    have_prev_d = have_prev_q;
    step_dir_d  = step_dir_q;
    step_err_d  = step_err_q;
    err_cnt_d   = err_cnt_q;
    if (accept) begin
      prev_bin_d  = bin;
      have_prev_d = 1'b1;
      step_err_d  = 1'b0;
      case (step_class_s)
        STEP_FIRST: step_dir_d = 1'b0;
        STEP_HOLD:  step_dir_d = step_dir_q;
        STEP_UP:    step_dir_d = 1'b1;
        STEP_DOWN:  step_dir_d = 1'b0;
        STEP_ERR: begin
          step_dir_d = 1'b0;
          step_err_d = 1'b1;
          if (err_cnt_q != {CW{1'b1}}) begin
            err_cnt_d = err_cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end else begin
            err_cnt_d = err_cnt_q;
          end
        end
        default: begin
          step_dir_d = 1'b0;
          step_err_d = 1'b0;
        end
      endcase
    end else begin
      prev_bin_d = prev_bin_q;
    end
  end

  // Checker state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_bin_q  <= {W{1'b0}};
      have_prev_q <= 1'b0;
      step_dir_q  <= 1'b0;
      step_err_q  <= 1'b0;
      err_cnt_q   <= {CW{1'b0}};
    end else begin
      prev_bin_q  <= prev_bin_d;
      have_prev_q <= have_prev_d;
      step_dir_q  <= step_dir_d;
      step_err_q  <= step_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign step_dir = step_dir_q;
  assign step_err = step_err_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: rtl/gray_to_bin_decoder.sv
// Streaming Gray-to-binary decoder with a one-entry valid/ready output register.
// Define GRAY_STEP_CHECK_EN to build the adjacency checker; otherwise step outputs are 0.
module gray_to_bin_decoder
  import gray_to_bin_decoder_pkg::*;
#(
  parameter int W  = W_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [W-1:0]  in_gray,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_bin,
  output logic          step_dir,
  output logic          step_err,
  output logic [CW-1:0] err_cnt
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_bin_q, out_bin_d;
  logic         in_ready_s;
  logic         accept_s;
  logic [W-1:0] bin_s;

  // Decode and output-register next state; a drain and an accept may share a cycle.
  always_comb begin
    bin_s       = W'(gray_to_bin(GRAY_MAX_W'(in_gray)));
    in_ready_s  = !out_valid_q || out_ready;
    accept_s    = in_valid && in_ready_s;
    out_valid_d = out_valid_q;
    out_bin_d   = out_bin_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_bin_d   = bin_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_bin_q   <= {W{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      out_bin_q   <= out_bin_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_bin   = out_bin_q;

`ifdef GRAY_STEP_CHECK_EN
  gray_step_checker #(
    .W  (W),
    .CW (CW)
  ) u_step_checker (
    .clk      (clk),
    .rst      (rst),
    .accept   (accept_s),
    .bin      (bin_s),
    .step_dir (step_dir),
    .step_err (step_err),
    .err_cnt  (err_cnt)
  );
`else
  assign step_dir = 1'b0;
  assign step_err = 1'b0;
  assign err_cnt  = {CW{1'b0}};
`endif

endmodule

// File: doc/gray_to_bin_decoder.md
# gray_to_bin_decoder

Streaming Gray-to-binary decoder with valid/ready handshake and a registered output stage. It is the receive-side counterpart of the team's binary-to-Gray encoder: it accepts Gray-coded samples, such as position-sensor codes or Gray pointers crossing a boundary, and returns the binary value. An optional sequence checker confirms that consecutive accepted codes are adjacent (±1 modulo 2^W), reports the step direction, and counts violations.

## Interface
Parameters:
- W, default 4: code width in bits, ≥2.
- CW, default 8: width of the violation counter.

Ports:
- clk, input, 1: single clock; all logic is rising-edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: in_gray holds a sample.
- in_gray, input, W: Gray-coded input sample.
- in_ready, output, 1: decoder can accept a sample this cycle.
- out_valid, output, 1: out_bin and the step flags are valid.
- out_ready, input, 1: downstream accepts the output.
- out_bin, output, W: decoded binary value.
- step_dir, output, 1: 1 means the step from the previous sample was +1; 0 means −1.
- step_err, output, 1: the sample is not adjacent to the previous accepted sample.
- err_cnt, output, CW: saturating count of step errors.

## Operation
- Decode:
  - bin[W-1] = g[W-1].
  - bin[i] = bin[i+1] ^ g[i], for i = W-2 down to 0.
- Accept condition: in_valid && in_ready.
- Output register:
  - One entry.
  - in_ready = !out_valid || out_ready, so new data can be accepted in the same cycle the held data drains.
- On accept, the following are loaded together: out_bin, step_dir, step_err.
- Output stall: while out_valid && !out_ready, all outputs hold stable and in_ready = 0.
- Sequence checker state:
  - prev_bin (W bits) and have_prev (1 bit).
  - Both update on every accept.
- Step classification, computing d = new − prev_bin mod 2^W:
  - have_prev = 0: step_err = 0, step_dir = 0. This is the first sample after reset.
  - d = 0 (repeat): step_err = 0, step_dir holds its previous value.
  - d = 1: step_dir = 1, step_err = 0.
  - d = 2^W − 1: step_dir = 0, step_err = 0.
  - Any other d: step_err = 1, step_dir = 0, and err_cnt increments.
- Wrap-around is legal in both directions: 2^W − 1 → 0 is an up step, and 0 → 2^W − 1 is a down step.
- A single-bit change in Gray code is not treated as adjacency. For W=4, Gray 0000 → 0100 (binary 0 → 7) is an error.
- err_cnt saturates at 2^CW − 1 and never wraps.

## Timing
- Latency: a sample accepted at edge N appears on out_bin with out_valid = 1 after edge N. Result latency is 1 cycle.
- Throughput: 1 sample per cycle while out_ready = 1.
- err_cnt updates on the same edge that loads the erroneous sample.
- Simultaneous drain and accept: out_valid stays 1 and the new data replaces the old data on that edge.
- Reset values: out_valid = 0, out_bin = 0, step_dir = 0, step_err = 0, err_cnt = 0, have_prev = 0, prev_bin = 0.
- in_ready is 1 in the cycle after reset.
- Reset mid-operation: any held output is discarded without handshake, and checker history is cleared.
- in_gray is sampled only on accept. Input changes while in_ready = 0 are ignored.

## Configuration
- GRAY_STEP_CHECK_EN defined: the checker (prev_bin, have_prev, classification, err_cnt) is built as specified.
- GRAY_STEP_CHECK_EN undefined:
  - Checker logic is absent.
  - step_dir, step_err and err_cnt are tied to 0.
  - Decode and handshake behaviour, including latency, are identical to the defined case.

## Structure
- Shared package/header contents:
  - Default widths W and CW.
  - Step-class encoding constants STEP_FIRST, STEP_HOLD, STEP_UP, STEP_DOWN, STEP_ERR, used internally and by the bench scoreboard.
  - The Gray-decode function, reusable by other blocks.
- One natural sub-module: gray_step_checker. It takes the decoded value and the accept strobe, and returns step_dir, step_err and err_cnt. It is instantiated only under GRAY_STEP_CHECK_EN.

## Test plan
All scenarios use W=4 and CW=8 unless stated.

- Sweep: feed Gray codes for binary 0..15 in order with out_ready = 1.
  - out_bin = 0..15, each one cycle after accept.
  - step_dir = 1 from the second sample onward.
  - step_err = 0 and err_cnt = 0 throughout.
- Wrap: feed binary 15 → 0 → 15, as Gray 1000 → 0000 → 1000.
  - step_dir = 1 and then 0.
  - No errors.
- Illegal jump: feed Gray 0000 → 0100.
  - out_bin = 7, step_err = 1, err_cnt = 1.
  - Feed 0100 again: step_err = 0 (repeat), and step_dir holds.
- Backpressure: hold out_ready = 0 for 3 cycles while in_valid = 1.
  - in_ready = 0 and outputs are stable.
  - On release, each sample is delivered exactly once, in order.
- Saturation: feed 300 illegal jumps with CW = 8.
  - err_cnt = 255 and holds at 255.
- Reset mid-stream: assert rst while out_valid = 1.
  - The next cycle shows all outputs at 0.
  - The first post-reset sample gets step_err = 0 whatever its value.
  - With GRAY_STEP_CHECK_EN undefined, err_cnt stays 0 throughout.
